// File: rtl/serial_parallel_rx_pkg.sv
// Shared definitions for the serial link: frame bit values, FSM state codes
// and the default word width that the transmitter and receiver agree on.
package serial_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [15:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_parallel_rx_strobe_timeout.sv
// Inter-strobe watchdog: saturating counter, cleared by clr, counting when en,
// flagging expired while the count equals TIMEOUT.
module strobe_timeout #(
  parameter int          CNT_W   = 18,
  parameter int unsigned TIMEOUT = 18'h3ffff
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LIMIT);

  // Holding at LIMIT keeps the flag asserted instead of wrapping past it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_parallel_rx.sv
// Strobe-sampled serial deserializer: start(0), DATA_W bits MSB-first, stop(1).
// Build option RX_PARITY_EN adds an even-parity bit before stop and a parity_err port.
module serial_parallel_rx
  import serial_pkg::*;
#(
  parameter int          DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned TIMEOUT = 18'h3ffff,
  parameter int          CNT_W   = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_stb,
  input  logic                          bit_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          data_valid,
  output logic                          busy,
  output logic                          frame_err,
`ifdef RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(DATA_W+1)-1:0]   bit_cnt_o
);

  localparam int                BCNT_W   = $clog2(DATA_W+1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_valid_q, data_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              expired;
`ifdef RX_PARITY_EN
  logic              parity_bad_q, parity_bad_d;
  logic              parity_err_q, parity_err_d;
`endif

  // Watchdog runs only inside a frame; any accepted strobe restarts it.
  strobe_timeout #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (bit_stb || (state_q == ST_IDLE)),
    .en      (1'b1),
    .expired (expired)
  );

  always_comb begin
    // NOTE: every target gets a default first so no branch can infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bit_stb && bit_i == START_BIT) begin
          state_d   = ST_DATA;
          shift_d   = '0;
          bit_cnt_d = '0;
`ifdef RX_PARITY_EN
          parity_bad_d = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (bit_stb) begin
          shift_d   = {shift_q[DATA_W-2:0], bit_i};
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else if (expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`ifdef RX_PARITY_EN
      ST_PARITY: begin
        if (bit_stb) begin
          parity_bad_d = (bit_i != even_parity(16'(shift_q)));
          state_d      = ST_STOP;
        end else if (expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`endif
      ST_STOP: begin
        if (bit_stb) begin
          state_d = ST_IDLE;
`ifdef RX_PARITY_EN
          // A parity failure overrides a good stop bit.
          if (bit_i == STOP_BIT && !parity_bad_q) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
            parity_err_d = parity_bad_q;
          end
`else
          if (bit_i == STOP_BIT) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
`endif
        end else if (expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values.
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_o     = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign bit_cnt_o  = bit_cnt_q;
`ifdef RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_parallel_rx.sv
// Self-checking bench for serial_parallel_rx: directed frames plus random traffic
// compared every cycle against a queue-based frame model.
module tb_serial_parallel_rx;

  localparam int DW = 8;
  localparam int TO = 16;
`ifdef RX_PARITY_EN
  localparam int FLEN = DW + 3;
`else
  localparam int FLEN = DW + 2;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       bit_stb;
  logic                       bit_i;
  logic [DW-1:0]              data_o;
  logic                       data_valid;
  logic                       busy;
  logic                       frame_err;
  logic [$clog2(DW+1)-1:0]    bit_cnt_o;
`ifdef RX_PARITY_EN
  logic                       parity_err;
`endif

  serial_parallel_rx #(
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .CNT_W   (18)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_stb    (bit_stb),
    .bit_i      (bit_i),
    .data_o     (data_o),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_err  (frame_err),
`ifdef RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .bit_cnt_o  (bit_cnt_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bits of the frame in flight (start bit first) and idle edges since the last strobe.
  logic           fq[$];
  int             gap;
  logic [DW-1:0]  m_data;
  logic           m_valid, m_err, m_perr;
  int             n_valid, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic stb, input logic b);
    int            w;
    logic          bad;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_perr  = 1'b0;
    if (stb) begin
      gap = 0;
      if (fq.size() == 0) begin
        if (b == 1'b0) fq.push_back(b);
      end else begin
        fq.push_back(b);
        if (fq.size() == FLEN) begin
          w = 0;
          for (int i = 1; i <= DW; i++) w = w * 2 + int'(fq[i]);
          bad = 1'b0;
`ifdef RX_PARITY_EN
          bad = (fq[DW+1] != ^(w[DW-1:0]));
`endif
          if (!bad && fq[FLEN-1] == 1'b1) begin
            m_data  = w[DW-1:0];
            m_valid = 1'b1;
          end else begin
            m_err  = 1'b1;
            m_perr = bad;
          end
          fq.delete();
        end
      end
    end else if (fq.size() != 0) begin
      if (gap == TO) begin
        m_err = 1'b1;
        fq.delete();
        gap = 0;
      end else begin
        gap++;
      end
    end
  endtask

  task automatic tick(input logic stb, input logic b);
    bit_stb = stb;
    bit_i   = b;
    @(posedge clk);
    model_edge(stb, b);
    @(negedge clk);
    if (data_valid) n_valid++;
    if (frame_err)  n_err++;
    check("outs", {busy, data_valid, frame_err, data_o},
                  {fq.size() != 0, m_valid, m_err, m_data});
`ifdef RX_PARITY_EN
    check("parity_err", parity_err, m_perr);
`endif
    bit_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bit_stb = 1'b0;
    bit_i   = 1'b0;
    rst     = 1'b1;
    #1;
    check("rst_outs", {busy, data_valid, frame_err, data_o}, 32'h0);
    check("rst_bitcnt", bit_cnt_o, 32'h0);
    fq.delete();
    gap     = 0;
    m_data  = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input logic stop, input int sp,
                            input logic par_ok);
    tick(1'b1, 1'b0);
    idle(sp);
    for (int i = DW - 1; i >= 0; i--) begin
      tick(1'b1, w[i]);
      idle(sp);
    end
`ifdef RX_PARITY_EN
    tick(1'b1, (^w) ^ ~par_ok);
    idle(sp);
`endif
    tick(1'b1, stop);
  endtask

  // Random frame with occasional long gaps, bad stop bits and bad parity.
  task automatic rand_frame();
    logic [DW-1:0] w;
    logic          frame_bits[$];
    w = DW'($urandom);
    frame_bits.push_back(1'b0);
    for (int i = DW - 1; i >= 0; i--) frame_bits.push_back(w[i]);
`ifdef RX_PARITY_EN
    frame_bits.push_back((^w) ^ ($urandom_range(0, 7) == 0));
`endif
    frame_bits.push_back($urandom_range(0, 9) != 0);
    foreach (frame_bits[i]) begin
      if ($urandom_range(0, 24) == 0) idle($urandom_range(TO - 1, TO + 2));
      else                            idle($urandom_range(0, 2));
      tick(1'b1, frame_bits[i]);
    end
    if ($urandom_range(0, 3) == 0) tick(1'b1, 1'b1);
  endtask

  initial begin
    int v0, e0;
    bit_stb = 1'b0;
    bit_i   = 1'b0;
    n_valid = 0;
    n_err   = 0;
    gap     = 0;
    m_data  = '0;
    do_reset();

    // Reset mid-frame, then a clean frame.
    tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    check("mid_busy", busy, 1'b1);
    v0 = n_valid; e0 = n_err;
    do_reset();
    send_frame(8'hC3, 1'b1, 0, 1'b1);
    check("c3_valid", data_valid, 1'b1);
    check("c3_data", data_o, 8'hC3);
    idle(2);
    check("c3_pulses", n_valid - v0, 1);
    check("c3_no_err", n_err - e0, 0);

    // Basic frame, strobes 5 clk apart.
    send_frame(8'hA5, 1'b1, 4, 1'b1);
    check("a5_valid", data_valid, 1'b1);
    check("a5_data", data_o, 8'hA5);
    check("a5_busy_low", busy, 1'b0);
    idle(1);
    check("a5_pulse_width", data_valid, 1'b0);

    // Bad stop bit keeps the previous word.
    send_frame(8'h3C, 1'b0, 1, 1'b1);
    check("bad_stop_err", frame_err, 1'b1);
    check("bad_stop_valid", data_valid, 1'b0);
    check("bad_stop_data", data_o, 8'hA5);
    check("bad_stop_idle", busy, 1'b0);
    send_frame(8'h5A, 1'b1, 0, 1'b1);
    check("after_bad_data", data_o, 8'h5A);

    // Idle-line 1s are ignored.
    tick(1'b1, 1'b1);
    check("idle_one_busy", busy, 1'b0);

    // Timeout: no strobe when the count has reached TO aborts.
    tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    check("to_bitcnt", bit_cnt_o, 3);
    idle(TO);
    check("to_pre_err", frame_err, 1'b0);
    check("to_pre_busy", busy, 1'b1);
    tick(1'b0, 1'b0);
    check("to_err", frame_err, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_data", data_o, 8'h5A);

    // A strobe in the limit cycle is accepted.
    tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b1); tick(1'b1, 1'b0);
    idle(TO);
    tick(1'b1, 1'b1);
    check("to_edge_err", frame_err, 1'b0);
    check("to_edge_busy", busy, 1'b1);
    check("to_edge_bitcnt", bit_cnt_o, 4);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
`ifdef RX_PARITY_EN
    tick(1'b1, 1'b1);
`endif
    tick(1'b1, 1'b1);
    check("to_edge_data", data_o, 8'hD3);

    // Back-to-back frames with held strobes.
    v0 = n_valid;
    send_frame(8'h01, 1'b1, 0, 1'b1);
    check("b2b_first", data_o, 8'h01);
    send_frame(8'hFF, 1'b1, 0, 1'b1);
    check("b2b_second", data_o, 8'hFF);
    check("b2b_pulses", n_valid - v0, 2);

`ifdef RX_PARITY_EN
    send_frame(8'h07, 1'b1, 0, 1'b1);
    check("par_ok_valid", data_valid, 1'b1);
    check("par_ok_data", data_o, 8'h07);
    idle(1);
    send_frame(8'h70, 1'b1, 0, 1'b0);
    check("par_bad_err", frame_err, 1'b1);
    check("par_bad_perr", parity_err, 1'b1);
    check("par_bad_data", data_o, 8'h07);
`endif

    idle(3);
    repeat (150) rand_frame();
    idle(TO + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
